// File: rtl/tx_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tx_gen_ctrl
//
// Transmit-side generation controller for the PCIe PIPE datapath. Pulls 64-bit
// words from the TX packet FIFO and serialises each one onto the PIPE TX bus in
// chunks whose width depends on the link generation latched when the word run
// started. Bytes leave least significant first, with a matching byte-enable.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   gen         in   3   link generation code (0..4 legal)
//   linkup      in   1   link up; low aborts everything and returns to IDLE
//   fifo_empty  in   1   TX FIFO has no word
//   fifo_rdata  in   64  FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  1   FIFO read strobe, one cycle per word
//   tx_data     out  32  PIPE TX data, zero above the active width
//   tx_valid    out  1   tx_data holds a chunk
//   tx_byte_en  out  4   byte-enable for the active width
//   pipe_ready  in   1   PIPE accepts the current chunk
//   gen_err     out  1   sticky unsupported-generation flag
//
// Configuration macro:
//   TX_GEN_CTRL_GEN_ERR_EN - when defined, gen_err latches high whenever the
//   FSM sits in IDLE with the link up and an illegal gen code. When undefined
//   gen_err is tied low. The datapath is identical in both builds.
// -----------------------------------------------------------------------------
module tx_gen_ctrl #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  gen,
  input  logic        linkup,
  input  logic        fifo_empty,
  input  logic [63:0] fifo_rdata,
  output logic        fifo_rd,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic [3:0]  tx_byte_en,
  input  logic        pipe_ready,
  output logic        gen_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  gen_q, gen_d;
  logic [63:0] shreg_q, shreg_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [5:0]  width;
  logic        gen_legal;
  logic [63:0] shreg_shifted;
  logic [2:0]  cnt_load;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_be;

  // Map a generation code onto its PIPE width in bits.
  function automatic logic [5:0] width_of(input logic [2:0] g);
    case (g)
      3'd0:    width_of = 6'(GEN1_PIPEWIDTH);
      3'd1:    width_of = 6'(GEN2_PIPEWIDTH);
      3'd2:    width_of = 6'(GEN3_PIPEWIDTH);
      3'd3:    width_of = 6'(GEN4_PIPEWIDTH);
      3'd4:    width_of = 6'(GEN5_PIPEWIDTH);
      default: width_of = 6'(GEN1_PIPEWIDTH);
    endcase
  endfunction

  assign gen_legal = (gen <= 3'd4);

  // Width always comes from the latched generation, so a gen change on the
  // input cannot alter the chunking of a word already in flight.
  assign width = width_of(gen_q);

  // Everything that depends on the active width: the shift step, the number
  // of chunks per word (minus one), the low chunk and its byte-enable.
  always_comb begin
    shreg_shifted = {8'd0, shreg_q[63:8]};
    cnt_load      = 3'd7;
    chunk_data    = {24'd0, shreg_q[7:0]};
    chunk_be      = 4'b0001;
    case (width)
      6'd16: begin
        shreg_shifted = {16'd0, shreg_q[63:16]};
        cnt_load      = 3'd3;
        chunk_data    = {16'd0, shreg_q[15:0]};
        chunk_be      = 4'b0011;
      end
      6'd32: begin
        shreg_shifted = {32'd0, shreg_q[63:32]};
        cnt_load      = 3'd1;
        chunk_data    = shreg_q[31:0];
        chunk_be      = 4'b1111;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gen_q   <= 3'd0;
      shreg_q <= 64'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A dropped link wins over every state and discards any
  // partially sent word. The last accepted chunk chains straight into the
  // next fetch when more data is waiting, which keeps the inter-word bubble
  // at two cycles (FETCH, WAIT) and leaves gen_q untouched.
  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (!linkup) begin
      state_d = IDLE;
      shreg_d = 64'd0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty && gen_legal) begin
            gen_d   = gen;
            state_d = FETCH;
          end
        end
        FETCH: begin
          state_d = WAIT;
        end
        WAIT: begin
          shreg_d = fifo_rdata;
          cnt_d   = cnt_load;
          state_d = SEND;
        end
        SEND: begin
          if (pipe_ready) begin
            shreg_d = shreg_shifted;
            if (cnt_q == 3'd0) begin
              cnt_d   = 3'd0;
              state_d = fifo_empty ? IDLE : FETCH;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs: everything decodes from registered state and data.
  assign fifo_rd    = (state_q == FETCH);
  assign tx_valid   = (state_q == SEND);
  assign tx_data    = tx_valid ? chunk_data : 32'd0;
  assign tx_byte_en = tx_valid ? chunk_be : 4'd0;

`ifdef TX_GEN_CTRL_GEN_ERR_EN
  logic gen_err_q, gen_err_d;

  // Sticky: once an illegal generation is seen while idle with the link up,
  // the flag holds until reset.
  assign gen_err_d = gen_err_q | ((state_q == IDLE) && linkup && !gen_legal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_err_q <= 1'b0;
    end else begin
      gen_err_q <= gen_err_d;
    end
  end

  assign gen_err = gen_err_q;
`else
  assign gen_err = 1'b0;
`endif

endmodule
